sync_fifo: RTL and testbench

Single-clock, parameterised first-word-fall-through FIFO with a depth of 2**SIZE entries, each DBITS wide. The rasterizer vertex-fetch unit uses it to buffer whole triangles (15 x 32-bit words = 480 bits) between the memory-read engine and the downstream rasterizer pipeline. It exposes full/empty and almost_full/half_full/almost_empty status flags for flow control.

---
 rtl/sync_fifo.sv | 60 ++++++
 tb/tb_sync_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO, 2**SIZE entries of DBITS bits.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow error outputs.
module sync_fifo #(
  parameter int DBITS = 32,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  output logic [DBITS-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             half_full,
  output logic             almost_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);
  localparam int DEPTH = 2 ** SIZE;
  logic [DBITS-1:0] mem [DEPTH];
  logic [SIZE-1:0] wr_ptr, rd_ptr;
  logic [SIZE:0] count;
  logic wr_ok, rd_ok;
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{SIZE{1'b0}}, wr_ok} - {{SIZE{1'b0}}, rd_ok};
    end
  assign empty        = count == '0;
  assign full         = count == (SIZE+1)'(DEPTH);
  assign almost_full  = count >= (SIZE+1)'(DEPTH - 1);
  assign half_full    = count >= (SIZE+1)'(DEPTH / 2);
  assign almost_empty = count <= (SIZE+1)'(1);
  assign dout         = empty ? '0 : mem[rd_ptr];
`ifdef FIFO_ERR_FLAGS_EN
  // with full, a read is always accepted, so "no read accepted" reduces to !rd
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) overflow <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo (DBITS=480, SIZE=4) with a queue-based reference model.
module tb_sync_fifo;
  localparam int DB = 480;
  localparam int DEPTH = 16;
  logic clk = 0, reset = 0, wr = 0, rd = 0;
  logic [DB-1:0] din = '0, dout;
  logic empty, full, almost_full, half_full, almost_empty;
  int checks = 0, failures = 0;
  logic [DB-1:0] q[$];

  sync_fifo #(.DBITS(DB), .SIZE(4)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .din(din), .dout(dout),
    .empty(empty), .full(full), .almost_full(almost_full),
    .half_full(half_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // reference model: a plain queue with the FIFO acceptance rules
  always @(posedge clk or negedge reset)
    if (!reset) q.delete();
    else begin
      automatic bit do_w = wr && q.size() < DEPTH;
      automatic bit do_r = rd && q.size() > 0;
      if (do_r) void'(q.pop_front());
      if (do_w) q.push_back(din);
    end

  always @(negedge clk) begin
    automatic int n = q.size();
    chk("m_empty", DB'(empty), DB'(n == 0));
    chk("m_full", DB'(full), DB'(n == DEPTH));
    chk("m_almost_full", DB'(almost_full), DB'(n >= DEPTH - 1));
    chk("m_half_full", DB'(half_full), DB'(n >= DEPTH / 2));
    chk("m_almost_empty", DB'(almost_empty), DB'(n <= 1));
    chk("m_dout", dout, n > 0 ? q[0] : '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string name, input logic [4:0] exp);
    chk(name, DB'({empty, almost_empty, half_full, almost_full, full}), DB'(exp));
  endtask

  initial begin
    step();
    step();
    flags("reset_flags", 5'b11000);
    chk("reset_dout", dout, '0);
    reset = 1;
    for (int i = 1; i <= 16; i++) begin
      wr = 1;
      din = DB'(i);
      step();
      if (i == 1) begin
        chk("w1_dout", dout, DB'(1));
        chk("w1_almost_empty", DB'(almost_empty), DB'(1));
      end
      if (i == 2) chk("w2_almost_empty", DB'(almost_empty), DB'(0));
      if (i == 7) chk("w7_half_full", DB'(half_full), DB'(0));
      if (i == 8) chk("w8_half_full", DB'(half_full), DB'(1));
      if (i == 14) chk("w14_almost_full", DB'(almost_full), DB'(0));
      if (i == 15) begin
        chk("w15_almost_full", DB'(almost_full), DB'(1));
        chk("w15_full", DB'(full), DB'(0));
      end
      if (i == 16) chk("w16_full", DB'(full), DB'(1));
    end
    din = DB'(99);
    step();
    wr = 0;
    flags("full_after_drop", 5'b00111);
    chk("full_head", dout, DB'(1));
    rd = 1;
    for (int i = 1; i <= 16; i++) begin
      chk("pop_order", dout, DB'(i));
      step();
    end
    rd = 0;
    flags("drained", 5'b11000);
    chk("drained_dout", dout, '0);
    wr = 1; rd = 1; din = DB'('hA5);
    step();
    wr = 0; rd = 0;
    chk("wr_rd_empty_empty", DB'(empty), DB'(0));
    chk("wr_rd_empty_dout", dout, DB'('hA5));
    wr = 1;
    for (int i = 1; i <= 4; i++) begin
      din = DB'('hB0 + i);
      step();
    end
    rd = 1; din = DB'('hC0);
    step();
    wr = 0;
    chk("wr_rd_5_head", dout, DB'('hB1));
    flags("wr_rd_5_flags", 5'b00000);
    for (int i = 1; i <= 5; i++) begin
      chk("wr_rd_5_order", dout, i == 5 ? DB'('hC0) : DB'('hB0 + i));
      step();
    end
    rd = 0;
    flags("after_5", 5'b11000);
    wr = 1;
    for (int i = 0; i < 3; i++) begin
      din = DB'(i);
      step();
    end
    for (int i = 3; i < 40; i++) begin
      wr = 1; rd = 0; din = DB'(i);
      step();
      wr = 0; rd = 1;
      chk("wrap_order", dout, DB'(i - 3));
      step();
    end
    for (int i = 37; i < 40; i++) begin
      chk("wrap_tail", dout, DB'(i));
      step();
    end
    rd = 0;
    flags("wrap_done", 5'b11000);
    wr = 1;
    for (int i = 0; i < 7; i++) begin
      din = DB'('h100 + i);
      step();
    end
    wr = 0;
    chk("pre_reset_head", dout, DB'('h100));
    #1 reset = 0;
    #1;
    flags("async_reset_flags", 5'b11000);
    chk("async_reset_dout", dout, '0);
    step();
    reset = 1;
    wr = 1; din = DB'('h1234);
    step();
    wr = 0;
    chk("post_reset_dout", dout, DB'('h1234));
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
